// File: rtl/ram_port_arbiter_if.sv
// Master-side bus of one RAM port, shared between a requesting master and the arbiter.
//
// Handshake: a master raises req with we/lock/addr/wdata and holds those fields
// stable until gnt is seen high in the same cycle; gnt high completes the
// command (writes complete on gnt). A granted read returns rvalid=1 with rdata
// exactly one cycle later. rdata is zero whenever rvalid is low.
interface ram_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-master arbiter in front of a single-port sync-write / registered-read RAM.
// M0 = CPU fetch/load-store, M1 = CORDIC result writer / debug loader.
// Per-cycle arbitration with burst locking (BURST_MAX) and starvation guard (MAX_WAIT).
// Optional macro ARB_ROUND_ROBIN_EN: ties alternate between masters; when
// undefined, ties always go to M0.
module ram_port_arbiter #(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int BURST_MAX = 4,
    parameter int MAX_WAIT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    ram_port_arbiter_if.slave   m0,
    ram_port_arbiter_if.slave   m1,
    output logic                ram_wr_en_o,
    output logic [AW-1:0]       ram_address_o,
    output logic [DW-1:0]       ram_data_in_o,
    input  logic [DW-1:0]       ram_data_out_i,
    output logic [1:0]          state_o
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [3:0] BURST_C = 4'(BURST_MAX);
    localparam logic [7:0] WAIT_C  = 8'(MAX_WAIT);

    logic [1:0]    state_q, state_d;
    logic [3:0]    burst_cnt_q, burst_cnt_d;
    logic [7:0]    wait0_q, wait0_d, wait1_q, wait1_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_id_q, rd_id_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;

    logic starve0, starve1, tie_pick1;
    logic idle_g0, idle_g1, use_idle;
    logic gnt0, gnt1, g0, g1;

    assign starve0 = m0.req && (wait0_q >= WAIT_C);
    assign starve1 = m1.req && (wait1_q >= WAIT_C);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    // Tie goes to whichever master did not win the previous grant.
    assign tie_pick1 = ~last_winner_q;

    // Remember the most recent winner (reset to M1 so M0 wins the first tie).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner_q <= 1'b1;
        end else if (g0 || g1) begin
            last_winner_q <= g1;
        end
    end
`else
    assign tie_pick1 = 1'b0;
`endif

    // Ownerless winner selection: starving masters first (M0 before M1), then sole requester, then tie policy.
    always_comb begin
        idle_g0 = 1'b0;
        idle_g1 = 1'b0;
        if (starve0) begin
            idle_g0 = 1'b1;
        end else if (starve1) begin
            idle_g1 = 1'b1;
        end else if (m0.req && m1.req) begin
            idle_g0 = ~tie_pick1;
            idle_g1 = tie_pick1;
        end else begin
            idle_g0 = m0.req;
            idle_g1 = m1.req;
        end
    end

    // Ownership FSM: owner priority, burst limit, preemption by a starving other master.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        use_idle    = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            ST_OWN0: begin
                if (starve1 || !m0.req) begin
                    use_idle = 1'b1;
                end else if (burst_cnt_q < BURST_C) begin
                    gnt0 = 1'b1;
                    if (m0.lock) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = 4'd0;
                    end
                end else begin
                    gnt1        = m1.req;
                    state_d     = ST_IDLE;
                    burst_cnt_d = 4'd0;
                end
            end
            ST_OWN1: begin
                if (starve0 || !m1.req) begin
                    use_idle = 1'b1;
                end else if (burst_cnt_q < BURST_C) begin
                    gnt1 = 1'b1;
                    if (m1.lock) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        state_d     = ST_IDLE;
                        burst_cnt_d = 4'd0;
                    end
                end else begin
                    gnt0        = m0.req;
                    state_d     = ST_IDLE;
                    burst_cnt_d = 4'd0;
                end
            end
            default: use_idle = 1'b1;
        endcase
        if (use_idle) begin
            gnt0 = idle_g0;
            gnt1 = idle_g1;
            if (idle_g0 && m0.lock) begin
                state_d     = ST_OWN0;
                burst_cnt_d = 4'd1;
            end else if (idle_g1 && m1.lock) begin
                state_d     = ST_OWN1;
                burst_cnt_d = 4'd1;
            end else begin
                state_d     = ST_IDLE;
                burst_cnt_d = 4'd0;
            end
        end
    end

    // Reset forces every grant low, so the RAM side also falls back to the (reset) held values.
    assign g0 = gnt0 && !rst;
    assign g1 = gnt1 && !rst;

    assign m0.gnt = g0;
    assign m1.gnt = g1;

    assign ram_wr_en_o   = g0 ? m0.we    : (g1 ? m1.we    : 1'b0);
    assign ram_address_o = g0 ? m0.addr  : (g1 ? m1.addr  : addr_q);
    assign ram_data_in_o = g0 ? m0.wdata : (g1 ? m1.wdata : data_q);

    // Wait counters saturate at MAX_WAIT while denied, clear on grant or when not requesting.
    always_comb begin
        wait0_d = 8'd0;
        wait1_d = 8'd0;
        if (m0.req && !g0) begin
            wait0_d = (wait0_q >= WAIT_C) ? wait0_q : wait0_q + 8'd1;
        end
        if (m1.req && !g1) begin
            wait1_d = (wait1_q >= WAIT_C) ? wait1_q : wait1_q + 8'd1;
        end
        rd_valid_d = (g0 && !m0.we) || (g1 && !m1.we);
        rd_id_d    = g1;
    end

    // Read tag routes next cycle's RAM data to the master that issued the read.
    assign m0.rvalid = rd_valid_q && !rd_id_q;
    assign m1.rvalid = rd_valid_q && rd_id_q;
    assign m0.rdata  = m0.rvalid ? ram_data_out_i : '0;
    assign m1.rdata  = m1.rvalid ? ram_data_out_i : '0;

    assign state_o = state_q;

    // State, counters, read tag and held RAM command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= 4'd0;
            wait0_q     <= 8'd0;
            wait1_q     <= 8'd0;
            rd_valid_q  <= 1'b0;
            rd_id_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            wait0_q     <= wait0_d;
            wait1_q     <= wait1_d;
            rd_valid_q  <= rd_valid_d;
            rd_id_q     <= rd_id_d;
            if (g0 || g1) begin
                addr_q <= ram_address_o;
                data_q <= ram_data_in_o;
            end
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed scenarios plus randomized
// traffic compared against a rule-level reference model and a shadow memory.
module tb_ram_port_arbiter;
    localparam int AW        = 8;
    localparam int DW        = 32;
    localparam int BURST_MAX = 4;
    localparam int MAX_WAIT  = 8;

    typedef struct packed {
        logic          req;
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.AW(AW), .DW(DW)) m0_bus();
    ram_port_arbiter_if #(.AW(AW), .DW(DW)) m1_bus();

    logic          ram_wr_en;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in;
    logic [DW-1:0] ram_data_out;
    logic [1:0]    dut_state;

    ram_port_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(BURST_MAX), .MAX_WAIT(MAX_WAIT)) dut (
        .clk            (clk),
        .rst            (rst),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_wr_en_o    (ram_wr_en),
        .ram_address_o  (ram_address),
        .ram_data_in_o  (ram_data_in),
        .ram_data_out_i (ram_data_out),
        .state_o        (dut_state)
    );

    // Environment RAM: sync write, registered read.
    logic [DW-1:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
        ram_data_out <= ram_mem[ram_address];
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW:0]   exp_q[$];        // {master id, expected read data}
    logic [DW-1:0] exp_mem [256];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int own, bcnt, lastw;
    int wt[2];
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;

    task automatic model_reset();
        own = -1; bcnt = 0; lastw = 1; wt[0] = 0; wt[1] = 0;
        hold_addr = '0; hold_data = '0;
        exp_q.delete();
    endtask

    function automatic int pick_free(input bit r0, input bit r1);
        if (r0 && wt[0] >= MAX_WAIT) return 0;
        if (r1 && wt[1] >= MAX_WAIT) return 1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (r0 && r1) begin
`ifdef ARB_ROUND_ROBIN_EN
            return 1 - lastw;
`else
            return 0;
`endif
        end
        return -1;
    endfunction

    task automatic model_step(input cmd_t c0, input cmd_t c1, output int win);
        bit r[2];
        bit lk[2];
        int oth;
        r[0] = c0.req; r[1] = c1.req; lk[0] = c0.lock; lk[1] = c1.lock;
        win = -1;
        if (own >= 0 && !((r[1-own] && wt[1-own] >= MAX_WAIT) || !r[own])) begin
            oth = 1 - own;
            if (bcnt < BURST_MAX) begin
                win = own;
                if (lk[own]) bcnt++;
                else begin own = -1; bcnt = 0; end
            end else begin
                win = r[oth] ? oth : -1;
                own = -1; bcnt = 0;
            end
        end else begin
            win = pick_free(r[0], r[1]);
            if (win >= 0 && lk[win]) begin own = win; bcnt = 1; end
            else begin own = -1; bcnt = 0; end
        end
        for (int i = 0; i < 2; i++) begin
            if (r[i] && win != i) wt[i] = (wt[i] >= MAX_WAIT) ? MAX_WAIT : wt[i] + 1;
            else wt[i] = 0;
        end
        if (win >= 0) lastw = win;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input cmd_t c0, input cmd_t c1);
        m0_bus.req = c0.req; m0_bus.we = c0.we; m0_bus.lock = c0.lock;
        m0_bus.addr = c0.addr; m0_bus.wdata = c0.wdata;
        m1_bus.req = c1.req; m1_bus.we = c1.we; m1_bus.lock = c1.lock;
        m1_bus.addr = c1.addr; m1_bus.wdata = c1.wdata;
    endtask

    // Called at posedge+1; drives one cycle, checks it, returns at next posedge+1.
    task automatic run_cycle(input cmd_t c0, input cmd_t c1, output bit g0, output bit g1);
        logic [DW:0]   e;
        logic [DW-1:0] ed0, ed1;
        bit            ev0, ev1;
        int            win;
        cmd_t          wc;
        drive(c0, c1);
        #3;
        g0 = m0_bus.gnt; g1 = m1_bus.gnt;
        ev0 = 0; ev1 = 0; ed0 = '0; ed1 = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[DW]) begin ev1 = 1; ed1 = e[DW-1:0]; end
            else begin ev0 = 1; ed0 = e[DW-1:0]; end
        end
        check_eq("m0_rvalid", m0_bus.rvalid, ev0);
        check_eq("m1_rvalid", m1_bus.rvalid, ev1);
        check_eq("m0_rdata", m0_bus.rdata, ed0);
        check_eq("m1_rdata", m1_bus.rdata, ed1);
        model_step(c0, c1, win);
        check_eq("m0_gnt", g0, win == 0);
        check_eq("m1_gnt", g1, win == 1);
        if (win >= 0) begin
            wc = (win == 1) ? c1 : c0;
            hold_addr = wc.addr; hold_data = wc.wdata;
            if (wc.we) exp_mem[wc.addr] = wc.wdata;
            else exp_q.push_back({win == 1, exp_mem[wc.addr]});
            check_eq("ram_wr_en", ram_wr_en, wc.we);
        end else begin
            check_eq("ram_wr_en", ram_wr_en, 1'b0);
        end
        check_eq("ram_address", ram_address, hold_addr);
        check_eq("ram_data_in", ram_data_in, hold_data);
        @(posedge clk); #1;
    endtask

    task automatic reset_dut();
        cmd_t busy;
        busy = '{req: 1'b1, we: 1'b1, lock: 1'b1, addr: 8'h55, wdata: 32'hDEAD_BEEF};
        rst = 1'b1;
        drive(busy, busy);
        @(posedge clk); #2;
        check_eq("rst_m0_gnt", m0_bus.gnt, 1'b0);
        check_eq("rst_m1_gnt", m1_bus.gnt, 1'b0);
        check_eq("rst_wr_en", ram_wr_en, 1'b0);
        check_eq("rst_address", ram_address, '0);
        check_eq("rst_data_in", ram_data_in, '0);
        check_eq("rst_rvalid", {m0_bus.rvalid, m1_bus.rvalid}, 2'b00);
        check_eq("rst_rdata", {m0_bus.rdata, m1_bus.rdata}, 64'd0);
        check_eq("rst_state", dut_state, 2'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive('0, '0);
        model_reset();
    endtask

    // ---------------- stimulus ----------------
    cmd_t idle_c = '0;
    cmd_t c0, c1;
    cmd_t pend[2];
    bit   g0, g1;
    int   first;
    bit   done1;
    int   exp_win[9];
    int   obs_win;
    int   k;
    int   p_req;

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0203;
        end
        ram_mem[8'h13] = 32'h4376_4700;
        for (int i = 0; i < 256; i++) exp_mem[i] = ram_mem[i];
        drive('0, '0);
        model_reset();
        reset_dut();

        // M0 reads the preloaded float at 0x13.
        c0 = '{req: 1'b1, we: 1'b0, lock: 1'b0, addr: 8'h13, wdata: '0};
        run_cycle(c0, idle_c, g0, g1);
        check_eq("d13_gnt", g0, 1'b1);
        check_eq("d13_rvalid", m0_bus.rvalid, 1'b1);
        check_eq("d13_rdata", m0_bus.rdata, 32'h4376_4700);
        run_cycle(idle_c, idle_c, g0, g1);

        // M1 write, then M0 reads the same address.
        c1 = '{req: 1'b1, we: 1'b1, lock: 1'b0, addr: 8'hFE, wdata: 32'h3E68_56A5};
        run_cycle(idle_c, c1, g0, g1);
        check_eq("dfe_wgnt", g1, 1'b1);
        check_eq("dfe_m1_rvalid", m1_bus.rvalid, 1'b0);
        c0 = '{req: 1'b1, we: 1'b0, lock: 1'b0, addr: 8'hFE, wdata: '0};
        run_cycle(c0, idle_c, g0, g1);
        check_eq("dfe_m0_rdata", m0_bus.rdata, 32'h3E68_56A5);
        check_eq("dfe_m1_rvalid2", m1_bus.rvalid, 1'b0);
        run_cycle(idle_c, idle_c, g0, g1);

        // Tie pattern: both request without lock for 4 cycles.
        reset_dut();
        for (int cyc = 0; cyc < 4; cyc++) begin
            c0 = '{req: 1'b1, we: 1'b0, lock: 1'b0, addr: 8'(cyc), wdata: '0};
            c1 = '{req: 1'b1, we: 1'b0, lock: 1'b0, addr: 8'(cyc + 8), wdata: '0};
            run_cycle(c0, c1, g0, g1);
`ifdef ARB_ROUND_ROBIN_EN
            check_eq("tie_winner", g1, cyc % 2 == 1);
`else
            check_eq("tie_winner", g1, 1'b0);
`endif
        end

        // Burst: M0 locked reads 0..7 while M1 asks for one read.
        reset_dut();
        exp_win = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        k = 0; done1 = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            c0 = '{req: k < 8, we: 1'b0, lock: 1'b1, addr: 8'(k), wdata: '0};
            c1 = '{req: !done1, we: 1'b0, lock: 1'b0, addr: 8'h80, wdata: '0};
            run_cycle(c0, c1, g0, g1);
            obs_win = g1 ? 1 : (g0 ? 0 : -1);
            check_eq("burst_winner", 64'(obs_win), 64'(exp_win[cyc]));
            if (g0) k++;
            if (g1) done1 = 1;
        end
        run_cycle(idle_c, idle_c, g0, g1);

        // Starvation: M0 requests continuously, M1 from cycle 0.
        reset_dut();
        first = -1; done1 = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            c0 = '{req: 1'b1, we: 1'b0, lock: 1'b0, addr: 8'(cyc), wdata: '0};
            c1 = '{req: !done1, we: 1'b0, lock: 1'b0, addr: 8'h40, wdata: '0};
            run_cycle(c0, c1, g0, g1);
            if (g1 && first < 0) begin first = cyc; done1 = 1; end
        end
`ifdef ARB_ROUND_ROBIN_EN
        check_eq("starve_cycle", 64'(first), 64'd1);
`else
        check_eq("starve_cycle", 64'(first), 64'(MAX_WAIT));
`endif
        run_cycle(idle_c, idle_c, g0, g1);

        // Randomized traffic, light then heavy load.
        reset_dut();
        pend[0] = '0; pend[1] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            p_req = (cyc < 1500) ? 55 : 95;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i].req && $urandom_range(0, 99) < p_req) begin
                    pend[i].req   = 1'b1;
                    pend[i].we    = $urandom_range(0, 2) == 0;
                    pend[i].lock  = $urandom_range(0, 99) < 40;
                    pend[i].addr  = 8'($urandom_range(0, 31));
                    pend[i].wdata = $urandom;
                end
            end
            run_cycle(pend[0], pend[1], g0, g1);
            if (g0) pend[0].req = 1'b0;
            if (g1) pend[1].req = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (pend[i].req && $urandom_range(0, 99) < 2) pend[i].req = 1'b0;
            end
        end
        run_cycle(idle_c, idle_c, g0, g1);

        // Reset asserted while an M1 read is granted: its rvalid must never appear.
        c1 = '{req: 1'b1, we: 1'b0, lock: 1'b1, addr: 8'h20, wdata: '0};
        drive(idle_c, c1);
        #2;
        check_eq("mid_pre_gnt", m1_bus.gnt, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("mid_gnt", {m0_bus.gnt, m1_bus.gnt}, 2'b00);
        check_eq("mid_wr_en", ram_wr_en, 1'b0);
        check_eq("mid_address", ram_address, '0);
        check_eq("mid_data_in", ram_data_in, '0);
        @(posedge clk); #1;
        check_eq("mid_rvalid_rst", m1_bus.rvalid, 1'b0);
        check_eq("mid_rdata_rst", m1_bus.rdata, '0);
        rst = 1'b0;
        drive('0, '0);
        model_reset();
        @(posedge clk); #1;
        check_eq("mid_rvalid_after", m1_bus.rvalid, 1'b0);
        check_eq("mid_state_after", dut_state, 2'd0);
        run_cycle(idle_c, idle_c, g0, g1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard bound on simulated time.
    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
